instr_decode_stage: RTL
=======================

// Module: instr_decode_stage
// PURPOSE
//   Registered successor to the combinational field splitter: a 2-entry IF/ID
//   buffer that accepts 32-bit MIPS words with valid/ready, extracts all fields,
//   classifies the format (R/I/J) and produces a DATA_W-wide extended immediate.
//   Sits between fetch and register read; absorbs one cycle of downstream stall.
// PARAMETERS
//   DATA_W  32  width of imm_ext (32 or 64)
//   PC_W    32  width of the PC carried alongside each instruction
// PORTS
//   clk       in   1       rising-edge clock
//   rst       in   1       asynchronous, active-high reset
//   in_valid  in   1       fetch presents in_instr/in_pc
//   in_ready  out  1       buffer can accept (occupancy < 2)
//   in_instr  in   32      raw instruction word
//   in_pc     in   PC_W    PC of in_instr
//   flush     in   1       sync discard of all buffered entries
//   out_valid out  1       head entry valid
//   out_ready in   1       decode consumer accepts head
//   out_pc    out  PC_W    PC of head
//   op        out  6       instr[31:26]
//   rs/rt/rd  out  5 each  instr[25:21]/[20:16]/[15:11]
//   shamt     out  5       instr[10:6]
//   funct     out  6       instr[5:0]
//   immi      out  16      instr[15:0]
//   immj      out  26      instr[25:0]
//   imm_ext   out  DATA_W  extended immediate (rules below)
//   fmt       out  2       0=R, 1=I, 2=J (3 never driven)
//   occ       out  2       entries held (0..2)
// BEHAVIOUR
//   - Reset: occ=0, out_valid=0, in_ready=1; all data outputs 0.
//   - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
//   - Latency: word accepted at edge N is on outputs with out_valid=1 after N
//     (registered), if buffer was empty. FIFO order preserved.
//   - in_ready = (occ!=2), driven from registered occ only (no comb path from
//     out_ready). Push+pop same cycle: occ unchanged, order kept.
//   - occ=2: no push; pop frees slot, in_ready=1 next cycle.
//   - Stall: while out_valid&&!out_ready all outputs held stable.
//   - Decode done at push time and stored per entry; outputs reflect head entry.
//   - fmt: op==0 -> R; op==2|op==3 -> J; else I.
//   - imm_ext: op 0x0C/0x0D/0x0E (andi/ori/xori) zero-extend immi;
//     op 0x0F (lui) = sign-extend {immi,16'h0} to DATA_W;
//     all other ops sign-extend immi. R/J formats still drive the rule result.
//   - flush: occ->0, out_valid->0 next edge; a push in the flush cycle is
//     dropped; flush has priority over push and pop.
//   - Data outputs when out_valid=0: hold last head value (don't care to bench).
//   - rst asserted mid-stream: buffer cleared immediately, reset values.
// CONFIGURATION
//   IDSTAGE_ILLEGAL_EN defined: extra port illegal (out,1), valid with head;
//     1 when op not in {00,02-0F,20,21,23,24,25,28,29,2B}; stored per entry,
//     reset 0. Undefined: port absent, no opcode check logic.
// TESTING
//   - Reset, then push 0x8C880004 (lw) pc 0x100, out_ready=1 -> next cycle
//     out_valid=1, op=0x23, rs=4, rt=8, imm_ext=0x00000004, fmt=1, out_pc=0x100.
//   - Push 0x3C01FFFF (lui) -> imm_ext=0xFFFF0000 (DATA_W=32) /
//     0xFFFFFFFFFFFF0000 (64); push 0x3421FFFF (ori) -> imm_ext=0x0000FFFF.
//   - out_ready=0, push 3 words back-to-back -> 2 accepted, in_ready=0 with
//     occ=2, outputs frozen on first; release -> words emerge in order, none lost.
//   - Push 0x00851020 (add) -> fmt=0, rd=2, funct=0x20, shamt=0; push 0x0C000040
//     (jal) -> fmt=2, immj=0x40.
//   - occ=2, assert flush with in_valid=1 -> next cycle occ=0, out_valid=0,
//     flushed and concurrent words never appear.
//   - IDSTAGE_ILLEGAL_EN: push 0xFC000000 -> illegal=1; 0x8C880004 -> illegal=0.

Source files
------------

// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_stage
// Purpose  : Two-entry IF/ID buffer that splits MIPS words into fields, classifies
//            R/I/J format and builds the extended immediate at push time.
//            Define IDSTAGE_ILLEGAL_EN to add the per-entry illegal-opcode flag.
// Revision : 1.0  initial release
// ============================================================================
module instr_decode_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       immi,
    output logic [25:0]       immj,
    output logic [DATA_W-1:0] imm_ext,
    output logic [1:0]        fmt,
`ifdef IDSTAGE_ILLEGAL_EN
    output logic              illegal,
`endif
    output logic [1:0]        occ
);

    localparam logic [1:0] c_FMT_R    = 2'd0;
    localparam logic [1:0] c_FMT_I    = 2'd1;
    localparam logic [1:0] c_FMT_J    = 2'd2;
    localparam logic [1:0] c_OCC_FULL = 2'd2;

    // ---------------- ingress decode ----------------
    logic [5:0]        w_in_op;
    logic [15:0]       w_in_immi;
    logic [1:0]        w_in_fmt;
    logic [DATA_W-1:0] w_in_imm_ext;

    assign w_in_op   = in_instr[31:26];
    assign w_in_immi = in_instr[15:0];

    always_comb begin
        w_in_fmt = c_FMT_I;
        if (w_in_op == 6'h00)
            w_in_fmt = c_FMT_R;
        else if (w_in_op == 6'h02 || w_in_op == 6'h03)
            w_in_fmt = c_FMT_J;
    end

    // Logical immediates zero-extend; lui places immi in the upper half of the
    // low word and sign-extends that 32-bit value into any wider datapath.
    always_comb begin
        w_in_imm_ext = DATA_W'($signed(w_in_immi));
        case (w_in_op)
            6'h0C, 6'h0D, 6'h0E: w_in_imm_ext = DATA_W'(w_in_immi);
            6'h0F:               w_in_imm_ext = DATA_W'($signed({w_in_immi, 16'h0000}));
            default:             w_in_imm_ext = DATA_W'($signed(w_in_immi));
        endcase
    end

`ifdef IDSTAGE_ILLEGAL_EN
    logic w_in_illegal;

    always_comb begin
        w_in_illegal = 1'b1;
        case (w_in_op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
                w_in_illegal = 1'b0;
            default:
                w_in_illegal = 1'b1;
        endcase
    end
`endif

    // ---------------- occupancy and pointers ----------------
    logic [1:0] r_occ;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic       w_push;
    logic       w_pop;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (r_occ != c_OCC_FULL);
    assign out_valid = (r_occ != 2'd0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;
    assign occ       = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else if (flush) begin
            r_occ    <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ---------------- entry storage ----------------
    logic [31:0]       r_instr   [2];
    logic [PC_W-1:0]   r_pc      [2];
    logic [1:0]        r_fmt     [2];
    logic [DATA_W-1:0] r_imm_ext [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_instr[i]   <= '0;
                r_pc[i]      <= '0;
                r_fmt[i]     <= c_FMT_R;
                r_imm_ext[i] <= '0;
            end
        end else if (w_push) begin
            r_instr[r_wr_ptr]   <= in_instr;
            r_pc[r_wr_ptr]      <= in_pc;
            r_fmt[r_wr_ptr]     <= w_in_fmt;
            r_imm_ext[r_wr_ptr] <= w_in_imm_ext;
        end
    end

`ifdef IDSTAGE_ILLEGAL_EN
    logic r_illegal [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal[0] <= 1'b0;
            r_illegal[1] <= 1'b0;
        end else if (w_push) begin
            r_illegal[r_wr_ptr] <= w_in_illegal;
        end
    end

    assign illegal = r_illegal[r_rd_ptr];
`endif

    // ---------------- head-entry outputs ----------------
    logic [31:0] w_head;

    assign w_head  = r_instr[r_rd_ptr];
    assign out_pc  = r_pc[r_rd_ptr];
    assign op      = w_head[31:26];
    assign rs      = w_head[25:21];
    assign rt      = w_head[20:16];
    assign rd      = w_head[15:11];
    assign shamt   = w_head[10:6];
    assign funct   = w_head[5:0];
    assign immi    = w_head[15:0];
    assign immj    = w_head[25:0];
    assign fmt     = r_fmt[r_rd_ptr];
    assign imm_ext = r_imm_ext[r_rd_ptr];

endmodule
`default_nettype wire
